// File: rtl/uart_v2_pkg.sv
// uart_v2_pkg: register map, bit indices, engine state encodings and divisor clamp for uart_fifo_v2.
package uart_v2_pkg;
   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_DIV    = 2'd3;
   localparam int ST_RXNE    = 0;
   localparam int ST_RXFULL  = 1;
   localparam int ST_TXEMPTY = 2;
   localparam int ST_TXFULL  = 3;
   localparam int ST_TXBUSY  = 4;
   localparam int ST_FERR    = 8;
   localparam int ST_RXCNT   = 16;
   localparam int CT_PAR_EN  = 0;
   localparam int CT_PAR_ODD = 1;
   localparam int CT_STOP2   = 2;
   localparam int CT_IE_RX   = 4;
   localparam int CT_IE_TXE  = 5;
   localparam int CT_IE_ERR  = 6;
   localparam int CT_LOOP    = 7;
   localparam logic [7:0] CTRL_MASK_BASE = 8'h77;
   localparam logic [15:0] DIV_MIN = 16'd4;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction
endpackage

// File: rtl/uart_v2_sync_fifo.sv
// uart_v2_sync_fifo: synchronous show-ahead FIFO, power-of-two depth, push+pop always honoured together.
module uart_v2_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign do_push = push & (~full | pop);
   assign do_pop = pop & (~empty | push);
   // An empty FIFO shows the incoming word so a simultaneous push/pop passes it through
   assign dout = empty ? din : mem_q[rp_q];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop) rp_q <= rp_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/uart_fifo_v2.sv
// uart_fifo_v2: Wishbone UART with RX/TX FIFOs, parity, 1/2 stop bits, sticky errors and a maskable IRQ.
// Define UART_LOOPBACK_EN to add CTRL[7] LOOP (TX serialiser -> RX synchroniser, pad held high).
module uart_fifo_v2
   import uart_v2_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd4167
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic        irq_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic valid, mapped, took, wr, rd;
   logic [1:0] off;
   logic ack_q, done_q, irq_q;
   logic [31:0] dat_q, rdata, status;
   logic [7:0] ctrl_q;
   logic [15:0] div_q;
   logic [3:0] err_q, err_set, err_clr;
   logic tx_push, tx_pop, tx_full, tx_empty, tx_busy;
   logic rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] tx_dout, rx_dout;
   logic [CW-1:0] tx_count, rx_count;
   logic rx_in;
   logic unused;
   tx_state_e tx_state_q;
   logic [15:0] tx_div_q, tx_cnt_q;
   logic [2:0] tx_bit_q;
   logic [7:0] tx_sh_q;
   logic tx_pen_q, tx_par_q, tx_stop2_q, tx_line_q, tx_tick, tx_done;
   rx_state_e rx_state_q;
   logic rx_s1_q, rx_s2_q, rx_prev_q, rx_pbit_q;
   logic [15:0] rx_div_q, rx_cnt_q;
   logic [2:0] rx_bit_q;
   logic [7:0] rx_sh_q;
   logic rx_tick, rx_end, par_bad, rx_good;
`ifdef UART_LOOPBACK_EN
   localparam logic [7:0] CTRL_MASK = CTRL_MASK_BASE | 8'h80;
   assign rx_in = ctrl_q[CT_LOOP] ? tx_line_q : uart_rx_i;
   assign uart_tx_o = tx_line_q | ctrl_q[CT_LOOP];
`else
   localparam logic [7:0] CTRL_MASK = CTRL_MASK_BASE;
   assign rx_in = uart_rx_i;
   assign uart_tx_o = tx_line_q;
`endif
   assign unused = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16], tx_count};
   assign valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign mapped = wbs_adr_i[7:4] == 4'd0;
   assign off = wbs_adr_i[3:2];
   // done_q blocks a second ack until the master drops the request
   assign took = valid & ~done_q;
   assign wr = took & wbs_we_i & mapped;
   assign rd = took & ~wbs_we_i & mapped;
   always_comb begin
      status = '0;
      status[ST_RXNE] = ~rx_empty;
      status[ST_RXFULL] = rx_full;
      status[ST_TXEMPTY] = tx_empty;
      status[ST_TXFULL] = tx_full;
      status[ST_TXBUSY] = tx_busy;
      status[ST_FERR +: 4] = err_q;
      status[ST_RXCNT +: 8] = 8'(rx_count);
   end
   assign rdata = ~mapped ? '0 :
                  off == OFF_DATA   ? (rx_empty ? '0 : {24'd0, rx_dout}) :
                  off == OFF_STATUS ? status :
                  off == OFF_CTRL   ? {24'd0, ctrl_q} : {16'd0, div_q};
   assign tx_push = wr & (off == OFF_DATA) & wbs_sel_i[0];
   assign rx_pop = rd & (off == OFF_DATA) & ~rx_empty;
   assign err_clr = (wr & (off == OFF_STATUS) & wbs_sel_i[1]) ? wbs_dat_i[11:8] : 4'd0;
   assign err_set = {tx_push & tx_full & ~tx_pop, rx_good & rx_full, rx_end & rx_s2_q & par_bad, rx_end & ~rx_s2_q};
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o = irq_q;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         done_q <= 1'b0;
         dat_q <= '0;
         ctrl_q <= '0;
         div_q <= DIV_RESET;
         err_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ack_q <= took;
         done_q <= valid;
         dat_q <= rd ? rdata : '0;
         if (wr && off == OFF_CTRL && wbs_sel_i[0]) ctrl_q <= wbs_dat_i[7:0] & CTRL_MASK;
         if (wr && off == OFF_DIV && |wbs_sel_i[1:0])
            div_q <= clamp_div({wbs_sel_i[1] ? wbs_dat_i[15:8] : div_q[15:8], wbs_sel_i[0] ? wbs_dat_i[7:0] : div_q[7:0]});
         err_q <= (err_q & ~err_clr) | err_set;
         irq_q <= (ctrl_q[CT_IE_RX] & ~rx_empty) | (ctrl_q[CT_IE_TXE] & tx_empty & ~tx_busy) | (ctrl_q[CT_IE_ERR] & |err_q);
      end
   end
   uart_v2_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .pop(tx_pop), .din(wbs_dat_i[7:0]),
      .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
   );
   uart_v2_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
      .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );
   assign tx_tick = tx_cnt_q == 16'd0;
   assign tx_done = (tx_state_q == TX_STOP) & tx_tick & ~(tx_stop2_q & (tx_bit_q == 3'd0));
   // Popping at the end of STOP chains frames with no idle gap
   assign tx_pop = ~tx_empty & ((tx_state_q == TX_IDLE) | tx_done);
   assign tx_busy = tx_state_q != TX_IDLE;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tx_state_q <= TX_IDLE;
         tx_div_q <= DIV_MIN;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q <= '0;
         tx_pen_q <= 1'b0;
         tx_par_q <= 1'b0;
         tx_stop2_q <= 1'b0;
         tx_line_q <= 1'b1;
      end else if (tx_pop) begin
         tx_state_q <= TX_START;
         tx_div_q <= div_q;
         tx_cnt_q <= div_q - 16'd1;
         tx_sh_q <= tx_dout;
         tx_pen_q <= ctrl_q[CT_PAR_EN];
         tx_par_q <= (^tx_dout) ^ ctrl_q[CT_PAR_ODD];
         tx_stop2_q <= ctrl_q[CT_STOP2];
         tx_line_q <= 1'b0;
      end else if (tx_done) begin
         tx_state_q <= TX_IDLE;
         tx_line_q <= 1'b1;
      end else if (tx_busy && !tx_tick) begin
         tx_cnt_q <= tx_cnt_q - 16'd1;
      end else if (tx_busy) begin
         tx_cnt_q <= tx_div_q - 16'd1;
         case (tx_state_q)
            TX_START: begin
               tx_state_q <= TX_DATA;
               tx_bit_q <= 3'd0;
               tx_line_q <= tx_sh_q[0];
            end
            TX_DATA: begin
               tx_bit_q <= tx_bit_q + 3'd1;
               tx_sh_q <= tx_sh_q >> 1;
               tx_line_q <= (tx_bit_q == 3'd7) ? (tx_pen_q ? tx_par_q : 1'b1) : tx_sh_q[1];
               if (tx_bit_q == 3'd7) tx_state_q <= tx_pen_q ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
               tx_state_q <= TX_STOP;
               tx_bit_q <= 3'd0;
               tx_line_q <= 1'b1;
            end
            default: tx_bit_q <= tx_bit_q + 3'd1;
         endcase
      end
   end
   assign rx_tick = rx_cnt_q == 16'd0;
   assign rx_end = (rx_state_q == RX_STOP) & rx_tick;
   assign par_bad = ctrl_q[CT_PAR_EN] & (rx_pbit_q ^ (^rx_sh_q) ^ ctrl_q[CT_PAR_ODD]);
   assign rx_good = rx_end & rx_s2_q & ~par_bad;
   assign rx_push = rx_good & ~rx_full;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_state_q <= RX_IDLE;
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_div_q <= DIV_MIN;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q <= '0;
         rx_pbit_q <= 1'b0;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         if (rx_state_q == RX_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_q <= RX_START;
               rx_div_q <= div_q;
               rx_cnt_q <= (div_q >> 1) - 16'd1;
            end
         end else if (!rx_tick) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
         end else begin
            rx_cnt_q <= rx_div_q - 16'd1;
            case (rx_state_q)
               RX_START: begin
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                  rx_bit_q <= 3'd0;
               end
               RX_DATA: begin
                  rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                  rx_bit_q <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= ctrl_q[CT_PAR_EN] ? RX_PARITY : RX_STOP;
               end
               RX_PARITY: begin
                  rx_pbit_q <= rx_s2_q;
                  rx_state_q <= RX_STOP;
               end
               default: rx_state_q <= RX_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_fifo_v2.sv
// tb_uart_fifo_v2: directed bench for uart_fifo_v2 with default parameters (8-entry FIFOs).
module tb_uart_fifo_v2;
   logic clk = 1'b0, rst = 1'b1;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0, rx = 1'b1;
   logic [3:0] sel = 4'h0;
   logic [31:0] adr = '0, dat_w = '0, rd;
   logic ack, tx, irq;
   logic [31:0] dat_r;
   int vec_cnt = 0, err_cnt = 0;
   always #5 clk = ~clk;
   uart_fifo_v2 dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
      .uart_rx_i(rx), .uart_tx_o(tx), .irq_o(irq)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
      logic got;
      got = 1'b0;
      q = '0;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_w = d; adr = 32'h3000_0000 | 32'(off);
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            q = dat_r;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      if (!got) check("ack timeout", 32'(got), 32'd1);
   endtask
   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] q;
      bus(1'b1, off, d, 4'hF, q);
   endtask
   task automatic rdr(input logic [7:0] off, output logic [31:0] q);
      bus(1'b0, off, 32'd0, 4'hF, q);
   endtask
   task automatic rx_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send_rx(input logic [7:0] b, input logic pen, input logic pbit, input logic stp, input int div);
      rx_bit(1'b0, div);
      for (int i = 0; i < 8; i++) rx_bit(b[i], div);
      if (pen) rx_bit(pbit, div);
      rx_bit(stp, div);
      rx_bit(1'b1, 2 * div);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      logic [9:0] frame;
      logic [7:0] fb;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst ack", 32'(ack), 32'd0);
      check("rst dat", dat_r, 32'd0);
      check("rst tx", 32'(tx), 32'd1);
      check("rst irq", 32'(irq), 32'd0);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_000C;
      @(posedge clk); #1;
      check("ack pulse", 32'(ack), 32'd1);
      check("div reset", dat_r, 32'd4167);
      @(posedge clk); #1;
      check("ack single", 32'(ack), 32'd0);
      check("dat idle zero", dat_r, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0100;
      n = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack) n++;
      end
      check("miss no ack", 32'(n), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rdr(8'h04, rd); check("rst status", rd, 32'h4);
      rdr(8'h08, rd); check("rst ctrl", rd, 32'h0);
      rdr(8'h40, rd); check("unmapped", rd, 32'h0);
      wr(8'h0C, 32'd2);
      rdr(8'h0C, rd); check("div clamp", rd, 32'd4);
      wr(8'h0C, 32'd8);
      wr(8'h00, 32'hA5);
      frame = {1'b1, 8'hA5, 1'b0};
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int j = 0; j < 80; j++) begin
         if (j % 8 == 0 || j % 8 == 7) check($sformatf("tx bit%0d@%0d", j / 8, j % 8), 32'(tx), 32'(frame[j / 8]));
         @(posedge clk); #1;
      end
      check("tx idle after frame", 32'(tx), 32'd1);
      rdr(8'h04, rd); check("tx status idle", rd, 32'h4);
      wr(8'h08, 32'h1);
      send_rx(8'h3C, 1'b1, 1'b1, 1'b1, 8);
      rdr(8'h04, rd); check("perr status", rd, 32'h204);
      wr(8'h04, 32'h200);
      send_rx(8'h3C, 1'b1, 1'b0, 1'b1, 8);
      rdr(8'h00, rd); check("rx parity ok data", rd, 32'h3C);
      rdr(8'h04, rd); check("status after parity", rd, 32'h4);
      wr(8'h08, 32'h0);
      for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 8);
      rdr(8'h04, rd); check("rx overflow status", rd, 32'h0008_0407);
      for (int i = 0; i < 8; i++) begin
         rdr(8'h00, rd);
         check($sformatf("rx fifo %0d", i), rd, 32'h10 + 32'(i));
      end
      rdr(8'h00, rd); check("rx empty read", rd, 32'h0);
      wr(8'h04, 32'h400);
      rdr(8'h04, rd); check("rxovr cleared", rd, 32'h4);
      wr(8'h08, 32'h40);
      check("irq pre ferr", 32'(irq), 32'd0);
      fb = 8'h55;
      rx_bit(1'b0, 8);
      for (int i = 0; i < 8; i++) rx_bit(fb[i], 8);
      rx = 1'b0;
      @(posedge clk); #1;
      check("irq before stop", 32'(irq), 32'd0);
      repeat (9) @(posedge clk);
      #1;
      check("irq after ferr", 32'(irq), 32'd1);
      rx_bit(1'b1, 16);
      rdr(8'h04, rd); check("ferr status", rd, 32'h104);
      wr(8'h04, 32'h100);
      @(posedge clk); #1;
      check("irq cleared", 32'(irq), 32'd0);
      wr(8'h08, 32'h0);
      wr(8'h0C, 32'd16);
      rx_bit(1'b0, 2);
      rx_bit(1'b1, 200);
      rdr(8'h04, rd); check("glitch status", rd, 32'h4);
      rdr(8'h00, rd); check("glitch no data", rd, 32'h0);
      for (int i = 0; i < 10; i++) wr(8'h00, 32'(i));
      rdr(8'h04, rd); check("tx overflow status", rd, 32'h818);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("tx after reset", 32'(tx), 32'd1);
      rdr(8'h04, rd); check("status after reset", rd, 32'h4);
      rdr(8'h0C, rd); check("div after reset", rd, 32'd4167);
`ifdef UART_LOOPBACK_EN
      wr(8'h0C, 32'd8);
      wr(8'h08, 32'h80);
      rdr(8'h08, rd); check("loop ctrl", rd, 32'h80);
      wr(8'h00, 32'h5A);
      n = 0;
      for (int j = 0; j < 120; j++) begin
         @(posedge clk); #1;
         if (!tx) n++;
      end
      check("loop tx held high", 32'(n), 32'd0);
      rdr(8'h00, rd); check("loop rx data", rd, 32'h5A);
`else
      wr(8'h08, 32'h80);
      rdr(8'h08, rd); check("loop bit absent", rd, 32'h0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/uart_fifo_v2.md
Name: uart_fifo_v2

Overview:
Parametrised successor UART for the user project area. A Wishbone slave with a programmable baud divisor, configurable RX/TX FIFO depth, optional parity and 1/2 stop bits. Reports sticky error status and raises one maskable level interrupt. Sits at BASE_ADDR on the user Wishbone bus; TX/RX are routed to mprj_io pads by the top level.

Parameters:
BASE_ADDR, 32'h3000_0000, window base; decode on wbs_adr_i[31:8] == BASE_ADDR[31:8]
FIFO_DEPTH, 8, entries per FIFO; power of two, 2..64
DIV_RESET, 16'd4167, baud divisor after reset (40 MHz / 9600)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, synchronous, active-high
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
uart_rx_i  in  1  serial input, asynchronous
uart_tx_o  out  1  serial output, idle high
irq_o  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high. Reset mid-frame aborts both engines and empties both FIFOs.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, irq_o=0, DIV=DIV_RESET, CTRL=0, STATUS sticky bits=0.
- Bus access: valid = cyc & stb & address hit. wbs_ack_o is a 1-cycle pulse, 1 cycle after valid. No new ack until valid drops. wbs_dat_o is registered with the ack and is 0 otherwise.
- Register map (offset = adr[3:2]):
  - 0x00 DATA: a write with sel[0] pushes dat[7:0] into TX FIFO. A read pops RX FIFO; an empty FIFO reads 0 with no pop.
  - 0x04 STATUS: [0] RXNE, [1] RXFULL, [2] TXEMPTY, [3] TXFULL, [4] TXBUSY, [8] FERR, [9] PERR, [10] RXOVR, [11] TXOVR, [23:16] rx_count. Bits [11:8] are sticky and write-1-to-clear.
  - 0x08 CTRL: [0] PAR_EN, [1] PAR_ODD, [2] STOP2, [4] IE_RX, [5] IE_TXE, [6] IE_ERR. Byte-lane writes honour sel.
  - 0x0C DIV: [15:0] clocks per bit. Written values <4 clamp to 4. Lanes honour sel.
  - Unmapped offsets read 0 and are still acked.
- Divisor timing: latched at each frame start, so a DIV write mid-frame applies from the next frame.
- TX engine:
  - States IDLE, START, DATA, PARITY, STOP.
  - IDLE with TX FIFO non-empty: pop the FIFO and go to START the following cycle.
  - Each state lasts DIV clocks. Data is sent LSB first over 8 bits.
  - PARITY only when PAR_EN; even parity by default, odd if PAR_ODD. STOP lasts 1 or 2 bit times.
  - Back-to-back frames: no idle gap.
- RX engine:
  - uart_rx_i passes through a 2-FF synchroniser. A falling edge in IDLE starts a frame.
  - Start bit is resampled at DIV/2; if high, abort to IDLE (glitch).
  - Data and parity bits are sampled at mid-bit; only the first stop bit is checked.
  - Stop low: set FERR, discard byte. Parity mismatch: set PERR, discard byte.
  - RX FIFO full on a good byte: set RXOVR, drop the new byte and keep the old contents.
- FIFO boundaries:
  - TX push when full: dropped, TXOVR set.
  - Push and pop in the same cycle on a full or empty FIFO are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Interrupt: irq_o = (IE_RX&RXNE) | (IE_TXE&TXEMPTY&~TXBUSY) | (IE_ERR&|STATUS[11:8]). Registered, so it has 1-cycle latency.

Optional Feature:
UART_LOOPBACK_EN:
- When defined: CTRL[7] LOOP connects the TX serialiser output to the RX synchroniser input, and holds uart_tx_o high.
- When undefined: CTRL[7] reads 0, writes are ignored, and no loopback mux exists.

Decomposition:
- Package uart_v2_pkg holds:
  - register offset constants;
  - STATUS and CTRL bit-index constants;
  - TX/RX state encodings;
  - DIV_MIN=4.
- Sub-module uart_v2_sync_fifo, parametrised by width and depth, instantiated twice. Ports: push, pop, din, dout (show-ahead), count, full, empty.

Test Plan:
- Reset, then write DIV=8 and write DATA=0xA5 -> uart_tx_o shows low start, bits 1,0,1,0,0,1,0,1, then high stop. Each bit lasts 8 clocks; the frame is 80 clocks.
- Set PAR_EN=1, PAR_ODD=0, drive RX frame 0x3C with parity bit 1 -> PERR=1, RXNE=0. Repeat with parity 0 -> DATA reads 0x3C.
- Drive FIFO_DEPTH+1 RX bytes with no reads -> RXFULL=1, RXOVR=1, and reads return the first 8 bytes in order. W1C write 0x400 to STATUS -> RXOVR=0.
- RX frame with stop bit low -> FERR=1 and no push. With IE_ERR=1, irq_o rises 1 cycle after FERR.
- 2-clock low glitch on uart_rx_i with DIV=16 -> no frame and status unchanged.
- With UART_LOOPBACK_EN and LOOP=1, write 0x5A -> RX DATA reads 0x5A and uart_tx_o stays 1 throughout.
